// File: rtl/tm_pkg.sv
// Shared constants for the timer/PWM peripheral: register addresses,
// CTRL bit positions and the PWM compare helper.
package tm_pkg;

    // Register addresses on the byte-wide slave port.
    localparam logic [1:0] TM_CTRL   = 2'd0;
    localparam logic [1:0] TM_PERIOD = 2'd1;
    localparam logic [1:0] TM_CMP    = 2'd2;
    localparam logic [1:0] TM_CNT    = 2'd3;

    // CTRL register bit positions.
    localparam int CTRL_EN      = 0;
    localparam int CTRL_EXT     = 1;
    localparam int CTRL_OVF_IE  = 2;
    localparam int CTRL_CMP_IE  = 3;
    localparam int CTRL_PWM_EN  = 4;
    localparam int CTRL_PWM_POL = 5;
    localparam int CTRL_CMPF    = 6;
    localparam int CTRL_OVFF    = 7;

    // Event input indices into the edge-detector bank.
    localparam int EV_COUNT = 0;
    localparam int EV_START = 1;
    localparam int EV_STOP  = 2;
    localparam int EV_NUM   = 3;

    // Raw PWM level before the odd/even split.
    // CMP=0 forces 0% duty and CMP>PERIOD forces 100% duty, independent of
    // where the counter happens to be (it may have been loaded above PERIOD).
    function automatic logic pwm_raw(
        input logic [7:0] cnt,
        input logic [7:0] cmp,
        input logic [7:0] period,
        input logic       pol
    );
        logic level;
        if (cmp == 8'd0) begin
            level = 1'b0;
        end else if (cmp > period) begin
            level = 1'b1;
        end else begin
            level = (cnt < cmp);
        end
        return level ^ pol;
    endfunction

endpackage

// File: rtl/tm_edge_detect.sv
// Rising-edge detector for a clk-synchronous event input.
// One history register; the pulse is high in the cycle where the input is 1
// and was 0 at the previous clock edge, so it is consumed at the next edge.
module tm_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic evnt,
    output logic rise
);

    logic evnt_prev_reg;

    // History of the event level from the previous clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            evnt_prev_reg <= 1'b0;
        end else begin
            evnt_prev_reg <= evnt;
        end
    end

    assign rise = evnt & ~evnt_prev_reg;

endmodule

// File: rtl/timer_modport.sv
// 8-bit timer/PWM peripheral with a 4-register byte-wide slave port.
// Counts clocks or Evnt0 edges, raises overflow/compare flags with a
// maskable level interrupt and drives PWM outputs from the CMP register.
module timer_modport
    import tm_pkg::*;
#(
    parameter int PWM_SIZE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          addr,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [7:0]          wdata,
    output logic [7:0]          rdata,
    input  logic                Evnt0,
    input  logic                Evnt1,
    input  logic                Evnt2,
    output logic [PWM_SIZE-1:0] PWM,
    output logic                Int
);

    // Register state.
    logic [7:0] ctrl_reg,   ctrl_next;
    logic [7:0] period_reg;
    logic [7:0] cmp_reg;
    logic [7:0] cnt_reg,    cnt_next;
    logic [7:0] rdata_reg,  rdata_next;

    // Decoded bus strobes.
    logic wr_ctrl, wr_period, wr_cmp, wr_cnt;

    // Event edge pulses, indexed by EV_COUNT / EV_START / EV_STOP.
    logic [EV_NUM-1:0] evnt_vec;
    logic [EV_NUM-1:0] evnt_rise;

    // Counter control.
    logic tick;
    logic wrap;
    logic ovf_hit;
    logic cmp_hit;
    logic raw;

    assign wr_ctrl   = wr_en && (addr == TM_CTRL);
    assign wr_period = wr_en && (addr == TM_PERIOD);
    assign wr_cmp    = wr_en && (addr == TM_CMP);
    assign wr_cnt    = wr_en && (addr == TM_CNT);

    assign evnt_vec[EV_COUNT] = Evnt0;
    assign evnt_vec[EV_START] = Evnt1;
    assign evnt_vec[EV_STOP]  = Evnt2;

    // One edge detector per event input.
    generate
        for (genvar gi = 0; gi < EV_NUM; gi++) begin : g_edge
            tm_edge_detect u_edge (
                .clk   (clk),
                .reset (reset),
                .evnt  (evnt_vec[gi]),
                .rise  (evnt_rise[gi])
            );
        end
    endgenerate

    // A tick is one counting step: every clock, or each Evnt0 rising edge.
    assign tick    = ctrl_reg[CTRL_EN] &
                     (ctrl_reg[CTRL_EXT] ? evnt_rise[EV_COUNT] : 1'b1);
    assign wrap    = (cnt_reg == period_reg);
    assign ovf_hit = tick & wrap;
    assign cmp_hit = tick & (cnt_reg == cmp_reg);

    // Counter next value: a CPU load beats a tick; PERIOD=0 pins CNT at 0.
    always_comb begin
        cnt_next = cnt_reg;
        if (wr_cnt) begin
            cnt_next = wdata;
        end else if (tick) begin
            cnt_next = wrap ? 8'd0 : cnt_reg + 8'd1;
        end
    end

    // CTRL next value: CPU write owns EN and config bits, events move EN
    // otherwise (stop wins over start), flags are set-dominant over W1C.
    always_comb begin
        ctrl_next = ctrl_reg;
        if (wr_ctrl) begin
            ctrl_next[CTRL_PWM_POL:CTRL_EN] = wdata[CTRL_PWM_POL:CTRL_EN];
        end else if (evnt_rise[EV_STOP]) begin
            ctrl_next[CTRL_EN] = 1'b0;
        end else if (evnt_rise[EV_START]) begin
            ctrl_next[CTRL_EN] = 1'b1;
        end
        ctrl_next[CTRL_CMPF] = (ctrl_reg[CTRL_CMPF] & ~(wr_ctrl & wdata[CTRL_CMPF]))
                               | cmp_hit;
        ctrl_next[CTRL_OVFF] = (ctrl_reg[CTRL_OVFF] & ~(wr_ctrl & wdata[CTRL_OVFF]))
                               | ovf_hit;
    end

    // Read mux over the pre-update register values.
    always_comb begin
        rdata_next = rdata_reg;
        if (rd_en) begin
            case (addr)
                TM_CTRL:   rdata_next = ctrl_reg;
                TM_PERIOD: rdata_next = period_reg;
                TM_CMP:    rdata_next = cmp_reg;
                default:   rdata_next = cnt_reg;
            endcase
        end
    end

    // Control, count and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg  <= 8'd0;
            cnt_reg   <= 8'd0;
            rdata_reg <= 8'd0;
        end else begin
            ctrl_reg  <= ctrl_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
        end
    end

    // Plain read/write configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_reg <= 8'd0;
            cmp_reg    <= 8'd0;
        end else begin
            if (wr_period) begin
                period_reg <= wdata;
            end
            if (wr_cmp) begin
                cmp_reg <= wdata;
            end
        end
    end

    assign rdata = rdata_reg;

    // Level interrupt straight from the flag and enable registers.
    assign Int = (ctrl_reg[CTRL_OVFF] & ctrl_reg[CTRL_OVF_IE]) |
                 (ctrl_reg[CTRL_CMPF] & ctrl_reg[CTRL_CMP_IE]);

    assign raw = pwm_raw(cnt_reg, cmp_reg, period_reg, ctrl_reg[CTRL_PWM_POL]);

    // Even outputs follow the raw level, odd outputs are its complement.
    generate
        for (genvar gi = 0; gi < PWM_SIZE; gi++) begin : g_pwm
            if ((gi % 2) == 0) begin : g_even
                assign PWM[gi] = ctrl_reg[CTRL_PWM_EN] & raw;
            end else begin : g_odd
                assign PWM[gi] = ctrl_reg[CTRL_PWM_EN] & ~raw;
            end
        end
    endgenerate

endmodule

// File: tb/tb_timer_modport.sv
// Directed bench for timer_modport. Inputs are driven and outputs sampled on
// the falling clock edge; every task starts and ends at a falling edge.
module tb_timer_modport;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PERIOD = 2'd1;
    localparam logic [1:0] A_CMP    = 2'd2;
    localparam logic [1:0] A_CNT    = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       Evnt0, Evnt1, Evnt2;
    logic [1:0] PWM;
    logic       Int;

    int n_compared   = 0;
    int n_mismatched = 0;

    timer_modport #(.PWM_SIZE(2)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .wdata (wdata),
        .rdata (rdata),
        .Evnt0 (Evnt0),
        .Evnt1 (Evnt1),
        .Evnt2 (Evnt2),
        .PWM   (PWM),
        .Int   (Int)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata;
    endtask

    // Samples PWM for n cycles: counts PWM[0] highs and PWM[1]!=~PWM[0] cycles.
    task automatic pwm_window(input int n, output int highs, output int bad_pair);
        highs = 0;
        bad_pair = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (PWM[0]) highs++;
            if (PWM[1] !== ~PWM[0]) bad_pair++;
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] cnt_exp [5];
        logic       int_exp [5];
        int highs, bad_pair;

        cnt_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        int_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        addr = 2'd0; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'd0;
        Evnt0 = 1'b0; Evnt1 = 1'b0; Evnt2 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state.
        check("reset PWM", PWM, 2'b00);
        check("reset Int", Int, 1'b0);
        check("reset rdata", rdata, 8'h00);
        for (int a = 0; a < 4; a++) begin
            bus_read(a[1:0], rd);
            check($sformatf("reset reg%0d", a), rd, 8'h00);
        end

        // Clock counting with PERIOD=3, overflow interrupt and W1C.
        bus_write(A_PERIOD, 8'd3);
        bus_write(A_CTRL, 8'h05);
        addr  = A_CNT;
        rd_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("wrap cnt[%0d]", k), rdata, cnt_exp[k]);
            check($sformatf("wrap int[%0d]", k), Int, int_exp[k]);
        end
        rd_en = 1'b0;
        bus_write(A_CTRL, 8'h85);
        check("w1c ovff int", Int, 1'b0);
        bus_read(A_CTRL, rd);
        check("w1c ctrl", rd, 8'h45);

        // Reset mid-count stops and clears everything.
        do_reset();
        bus_read(A_CNT, rd);
        check("midreset cnt", rd, 8'h00);
        bus_read(A_CTRL, rd);
        check("midreset ctrl", rd, 8'h00);

        // PERIOD=0: CNT pinned at 0, flags set on every tick.
        bus_write(A_CTRL, 8'h01);
        repeat (3) @(negedge clk);
        bus_read(A_CNT, rd);
        check("period0 cnt", rd, 8'h00);
        bus_read(A_CTRL, rd);
        check("period0 ctrl", rd, 8'hC1);

        // External counting: four short pulses and one held pulse.
        do_reset();
        bus_write(A_PERIOD, 8'hFF);
        bus_write(A_CTRL, 8'h03);
        for (int p = 0; p < 4; p++) begin
            Evnt0 = 1'b1;
            @(negedge clk);
            Evnt0 = 1'b0;
            @(negedge clk);
        end
        Evnt0 = 1'b1;
        repeat (5) @(negedge clk);
        Evnt0 = 1'b0;
        @(negedge clk);
        bus_read(A_CNT, rd);
        check("ext cnt", rd, 8'd5);

        // PWM with PERIOD=9, CMP=3 on two outputs.
        do_reset();
        bus_write(A_PERIOD, 8'd9);
        bus_write(A_CMP, 8'd3);
        bus_write(A_CTRL, 8'h11);
        pwm_window(20, highs, bad_pair);
        check("pwm duty", highs, 6);
        check("pwm complement", bad_pair, 0);
        bus_write(A_CTRL, 8'h31);
        pwm_window(20, highs, bad_pair);
        check("pwm pol duty", highs, 14);
        check("pwm pol complement", bad_pair, 0);
        bus_write(A_CTRL, 8'h11);
        bus_write(A_CMP, 8'd0);
        pwm_window(20, highs, bad_pair);
        check("pwm cmp0 duty", highs, 0);
        bus_write(A_CMP, 8'd12);
        pwm_window(20, highs, bad_pair);
        check("pwm cmp>period duty", highs, 20);
        bus_write(A_CTRL, 8'h01);
        @(negedge clk);
        check("pwm disabled", PWM, 2'b00);

        // Start/stop events.
        do_reset();
        bus_write(A_PERIOD, 8'hFF);
        bus_write(A_CMP, 8'h80);
        Evnt1 = 1'b1;
        @(negedge clk);
        Evnt1 = 1'b0;
        repeat (4) @(negedge clk);
        Evnt2 = 1'b1;
        @(negedge clk);
        Evnt2 = 1'b0;
        bus_read(A_CNT, rd);
        check("start/stop cnt", rd, 8'd5);
        repeat (5) @(negedge clk);
        bus_read(A_CNT, rd);
        check("frozen cnt", rd, 8'd5);
        Evnt1 = 1'b1;
        @(negedge clk);
        Evnt1 = 1'b0;
        @(negedge clk);
        Evnt1 = 1'b1;
        Evnt2 = 1'b1;
        @(negedge clk);
        Evnt1 = 1'b0;
        Evnt2 = 1'b0;
        repeat (3) @(negedge clk);
        bus_read(A_CNT, rd);
        check("both events cnt", rd, 8'd7);
        bus_read(A_CTRL, rd);
        check("both events ctrl", rd, 8'h00);

        // CPU load of CNT beats a simultaneous tick.
        do_reset();
        bus_write(A_PERIOD, 8'hFF);
        bus_write(A_CMP, 8'h80);
        bus_write(A_CTRL, 8'h01);
        repeat (3) @(negedge clk);
        bus_write(A_CNT, 8'h10);
        bus_read(A_CNT, rd);
        check("cnt load vs tick", rd, 8'h10);

        // Flag set beats W1C clear in the same cycle.
        do_reset();
        bus_write(A_CTRL, 8'h01);
        @(negedge clk);
        bus_write(A_CTRL, 8'h80);
        bus_read(A_CTRL, rd);
        check("ovf set vs w1c", rd, 8'hC0);
        bus_write(A_CTRL, 8'hC0);
        bus_read(A_CTRL, rd);
        check("w1c idle clear", rd, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
